imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 135 +++++++++++++
 tb/tb_imem_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// ============================================================================
// imem_responder : icache refill responder, busywait + word-by-word beats.
// Option IMEM_BOUNDS_CHECK_EN: out-of-range blocks return NOPs with MEM_ERROR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MEM_READ_REQ,
  input  logic [ADDR_WIDTH-1:0]        MEM_ADDRESS,
  output logic                         MEM_BUSYWAIT,
  output logic [DATA_WIDTH-1:0]        MEM_READDATA,
  output logic                         MEM_READDATA_VALID,
  input  logic                         LOAD_EN,
  input  logic [$clog2(MEM_DEPTH)-1:0] LOAD_ADDR,
  input  logic [DATA_WIDTH-1:0]        LOAD_DATA
`ifdef IMEM_BOUNDS_CHECK_EN
  ,
  output logic                         MEM_ERROR
`endif
);

  localparam int BPW     = DATA_WIDTH / 8;
  localparam int WPB     = BLOCK_SIZE / BPW;
  localparam int OFF     = $clog2(BLOCK_SIZE);
  localparam int BPW_LOG = $clog2(BPW);
  localparam int MW      = $clog2(MEM_DEPTH);
  localparam int BW      = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(WPB - 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2} state_t;

  state_t                  state;
  logic [BW-1:0]           beat;
  logic [CW-1:0]           cnt;
  logic [ADDR_WIDTH-1:0]   base_word;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    accept;
  logic                    issue;
  logic                    issue_last;
  logic [ADDR_WIDTH-1:0]   req_word;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   beat_data;

  // A beat is registered on the edge that leaves the acceptance/WAIT cycle,
  // so the first VALID appears LATENCY+1 cycles after acceptance.
  assign req_word   = (MEM_ADDRESS >> OFF) << (OFF - BPW_LOG);
  assign accept     = (state == IDLE) && MEM_READ_REQ;
  assign issue      = (accept && (LATENCY == 0)) ||
                      ((state == WAIT) && (cnt == '0)) ||
                      (state == XFER);
  assign issue_last = issue && (beat == LAST_BEAT);
  assign word_idx   = ((state == IDLE) ? req_word : base_word) + ADDR_WIDTH'(beat);
  assign rd_word    = mem[MW'(word_idx)];

  assign MEM_BUSYWAIT = (accept || (state == WAIT) || (state == XFER)) && !issue_last;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic oob;
  logic oob_now;
  assign oob_now   = (state == IDLE) ? (|(req_word >> MW)) : oob;
  assign beat_data = oob_now ? DATA_WIDTH'(32'h0000_0013) : rd_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      oob       <= 1'b0;
      MEM_ERROR <= 1'b0;
    end else begin
      if (accept) oob <= |(req_word >> MW);
      MEM_ERROR <= issue && oob_now;
    end
  end
`else
  assign beat_data = rd_word;
`endif

  // Storage is never reset; preload writes land after the same-cycle read.
  always_ff @(posedge clk) begin
    if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      beat               <= '0;
      cnt                <= '0;
      base_word          <= '0;
      MEM_READDATA       <= '0;
      MEM_READDATA_VALID <= 1'b0;
    end else begin
      MEM_READDATA_VALID <= issue;
      if (issue) MEM_READDATA <= beat_data;
      case (state)
        IDLE: begin
          if (MEM_READ_REQ) begin
            base_word <= req_word;
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        XFER: ;
        default: state <= IDLE;
      endcase
      if (issue) begin
        if (issue_last) begin
          state <= IDLE;
          beat  <= '0;
        end else begin
          state <= XFER;
          beat  <= beat + BW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: one LATENCY=4 and one LATENCY=0 instance.
`default_nettype none

module tb_imem_responder;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req4, req0;
  logic [31:0] addr;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;
  logic        busy4, valid4, busy0, valid0;
  logic [31:0] rdata4, rdata0;
`ifdef IMEM_BOUNDS_CHECK_EN
  logic        err4, err0;
`endif

  int tests = 0;
  int fails = 0;
  exp_t        sb4[$];
  logic [31:0] sb0[$];

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(4)) u4 (
    .clk(clk), .reset(rst), .MEM_READ_REQ(req4), .MEM_ADDRESS(addr),
    .MEM_BUSYWAIT(busy4), .MEM_READDATA(rdata4), .MEM_READDATA_VALID(valid4),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
`ifdef IMEM_BOUNDS_CHECK_EN
    , .MEM_ERROR(err4)
`endif
  );

  imem_responder #(.LATENCY(0)) u0 (
    .clk(clk), .reset(rst), .MEM_READ_REQ(req0), .MEM_ADDRESS(addr),
    .MEM_BUSYWAIT(busy0), .MEM_READDATA(rdata0), .MEM_READDATA_VALID(valid0),
    .LOAD_EN(load_en), .LOAD_ADDR(load_addr), .LOAD_DATA(load_data)
`ifdef IMEM_BOUNDS_CHECK_EN
    , .MEM_ERROR(err0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected beat whenever a VALID pulse is presented.
  always @(negedge clk) begin
    if (valid4 === 1'b1) begin
      if (sb4.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb4_unexpected: got %h expected no beat", rdata4);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        chk("data4", rdata4, e.d);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("error4", {31'd0, err4}, {31'd0, e.e});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (sb0.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb0_unexpected: got %h expected no beat", rdata0);
      end else begin
        chk("data0", rdata0, sb0.pop_front());
      end
    end
  end

  // One LATENCY=4 transaction: checks busywait/valid timing cycle by cycle.
  task automatic req_lat4(input logic [31:0] a, input logic [31:0] e0, input logic [31:0] e1,
                          input logic err, input bit early, input int load_at);
    sb4.push_back('{e0, err});
    sb4.push_back('{e1, err});
    addr = a;
    req4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("busy4", {31'd0, busy4}, {31'd0, (k <= 4)});
      chk("valid4", {31'd0, valid4}, {31'd0, (k == 5 || k == 6)});
      if (k == 7) chk("hold4", rdata4, e1);
      @(posedge clk); #1;
      if (early && k == 0) begin
        addr = 32'h0000_0010;
        req4 = 1'b0;
      end
      if (k == 5) req4 = 1'b0;
      load_en   = (k + 1 == load_at);
      load_addr = 10'd0;
      load_data = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    rst = 1'b1; req4 = 1'b0; req0 = 1'b0; addr = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    // Preload while reset is held.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = 10'(i); load_data = 32'hA000_0000 + 32'(i);
    end
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy4}, 32'd0);
    chk("rst_valid", {31'd0, valid4}, 32'd0);
    chk("rst_data", rdata4, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Offset bits ignored; LATENCY=4 timing.
    req_lat4(32'h0000_0004, 32'hA000_0000, 32'hA000_0001, 1'b0, 1'b0, -1);

    // LATENCY=0: data on the next edge, one busy cycle.
    addr = 32'h0000_0008; req0 = 1'b1;
    sb0.push_back(32'hA000_0002); sb0.push_back(32'hA000_0003);
    @(negedge clk);
    chk("l0_busy_c0", {31'd0, busy0}, 32'd1);
    chk("l0_valid_c0", {31'd0, valid0}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l0_busy_c1", {31'd0, busy0}, 32'd0);
    chk("l0_valid_c1", {31'd0, valid0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    chk("l0_valid_c2", {31'd0, valid0}, 32'd1);
    chk("l0_busy_c2", {31'd0, busy0}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l0_valid_c3", {31'd0, valid0}, 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of WAIT.
    addr = 32'h0000_0000; req4 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req4 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wrst_busy", {31'd0, busy4}, 32'd0);
    chk("wrst_valid", {31'd0, valid4}, 32'd0);
    chk("wrst_data", rdata4, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req_lat4(32'h0000_0000, 32'hA000_0000, 32'hA000_0001, 1'b0, 1'b0, -1);

    // Address change and request drop after acceptance: no abort.
    req_lat4(32'h0000_0000, 32'hA000_0000, 32'hA000_0001, 1'b0, 1'b1, -1);

    // Preload collides with the beat-0 read: old value first, new value next.
    req_lat4(32'h0000_0000, 32'hA000_0000, 32'hA000_0001, 1'b0, 1'b0, 4);
    req_lat4(32'h0000_0000, 32'hDEAD_BEEF, 32'hA000_0001, 1'b0, 1'b0, -1);

    // Block beyond MEM_DEPTH.
`ifdef IMEM_BOUNDS_CHECK_EN
    req_lat4(32'h0000_1000, 32'h0000_0013, 32'h0000_0013, 1'b1, 1'b0, -1);
`else
    req_lat4(32'h0000_1000, 32'hDEAD_BEEF, 32'hA000_0001, 1'b0, 1'b0, -1);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb4_drained", 32'(sb4.size()), 32'd0);
    chk("sb0_drained", 32'(sb0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
